wb_stream_hub: RTL and testbench

//  Multi-channel Wishbone-to-stream bridge for the 32-bit I/O bus: NUM_CH independent byte/word channels,

---
 rtl/wb_stream_hub_pkg.sv | 29 ++
 rtl/wb_stream_hub_sync_fifo.sv | 55 +++++
 rtl/wb_stream_hub.sv | 182 ++++++++++++++++++
 tb/tb_wb_stream_hub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_hub_pkg.sv
// Shared definitions for wb_stream_hub: register offsets, STATUS layout and read-data formatting.
package wb_stream_hub_pkg;

    localparam int unsigned DATA_FIELD_W = 16;
    localparam int unsigned VALID_BIT    = 31;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] tx_count;
        logic [7:0] rx_count;
        logic [4:0] rsvd_lo;
        logic       tx_empty;
        logic       tx_full;
        logic       rx_nonempty;
    } status_t;

    // DATA read word: popped byte/word in the low half, valid flag in the top bit.
    function automatic logic [31:0] data_word(input logic [DATA_FIELD_W-1:0] d);
        logic [31:0] w;
        w            = 32'(d);
        w[VALID_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/wb_stream_hub_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; push into full is
// accepted only together with a pop in the same cycle.
module wb_stream_hub_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_stream_hub.sv
// Multi-channel Wishbone-to-stream bridge with per-channel TX/RX FIFOs and status.
// Define WB_STREAM_HUB_IRQ_EN to add the IRQ_EN registers and the irq output.
module wb_stream_hub
    import wb_stream_hub_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  adr_i,
    input  logic [31:0]                  dat_i,
    output logic [31:0]                  dat_o,
    input  logic                         we_i,
    input  logic [3:0]                   sel_i,
    input  logic                         stb_i,
    input  logic                         cyc_i,
    output logic                         ack_o,
    output logic                         err_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] tx_data,
    output logic [NUM_CH-1:0]            tx_valid,
    input  logic [NUM_CH-1:0]            tx_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rx_data,
    input  logic [NUM_CH-1:0]            rx_valid,
    output logic [NUM_CH-1:0]            rx_ready
`ifdef WB_STREAM_HUB_IRQ_EN
    ,
    output logic                         irq
`endif
);

    localparam int unsigned CW = FIFO_DEPTH_LOG2 + 1;

    logic [2:0]            ch;
    logic [1:0]            rsel;
    logic                  req;
    logic                  ch_ok;
    logic                  data_wr;
    logic                  data_rd;
    logic [NUM_CH-1:0]     tx_push, tx_pop, tx_full, tx_empty;
    logic [NUM_CH-1:0]     rx_push, rx_pop, rx_full, rx_empty;
    logic [CW-1:0]         tx_count [NUM_CH];
    logic [CW-1:0]         rx_count [NUM_CH];
    logic [DATA_WIDTH-1:0] rx_head  [NUM_CH];
    logic [1:0]            irq_en   [NUM_CH];

    logic                  sel_tx_full;
    logic                  sel_rx_empty;
    logic [DATA_WIDTH-1:0] sel_rx_head;
    status_t               sel_status;
    logic [1:0]            sel_irq_en;
    logic                  ack_d;
    logic                  err_d;
    logic [31:0]           rdata_d;
    logic                  unused_bits;

    assign ch          = adr_i[6:4];
    assign rsel        = adr_i[3:2];
    assign req         = stb_i & cyc_i & ~ack_o & ~err_o;
    assign ch_ok       = 32'(ch) < NUM_CH;
    assign data_wr     = req & ch_ok & we_i & (rsel == REG_DATA) & sel_i[0];
    assign data_rd     = req & ch_ok & ~we_i & (rsel == REG_DATA);
    assign unused_bits = ^{adr_i, dat_i, sel_i};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign tx_push[c]  = data_wr & (ch == 3'(c)) & ~tx_full[c];
        assign tx_valid[c] = ~tx_empty[c];
        assign tx_pop[c]   = tx_valid[c] & tx_ready[c];
        assign rx_ready[c] = ~rx_full[c];
        assign rx_push[c]  = rx_valid[c] & rx_ready[c];
        assign rx_pop[c]   = data_rd & (ch == 3'(c)) & ~rx_empty[c];

        wb_stream_hub_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (tx_push[c]),
            .push_data (dat_i[DATA_WIDTH-1:0]),
            .pop       (tx_pop[c]),
            .pop_data  (tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .full      (tx_full[c]),
            .empty     (tx_empty[c]),
            .count     (tx_count[c])
        );

        wb_stream_hub_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (rx_push[c]),
            .push_data (rx_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (rx_pop[c]),
            .pop_data  (rx_head[c]),
            .full      (rx_full[c]),
            .empty     (rx_empty[c]),
            .count     (rx_count[c])
        );

`ifdef WB_STREAM_HUB_IRQ_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                irq_en[c] <= 2'b00;
            end else if (req && ch_ok && we_i && rsel == REG_IRQ_EN && sel_i[0] && ch == 3'(c)) begin
                irq_en[c] <= dat_i[1:0];
            end
        end
`else
        assign irq_en[c] = 2'b00;
`endif
    end

    // Mux the addressed channel's state onto the response path.
    always_comb begin
        sel_tx_full  = 1'b0;
        sel_rx_empty = 1'b1;
        sel_rx_head  = '0;
        sel_status   = '0;
        sel_irq_en   = 2'b00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 3'(c)) begin
                sel_tx_full            = tx_full[c];
                sel_rx_empty           = rx_empty[c];
                sel_rx_head            = rx_head[c];
                sel_status.rx_nonempty = ~rx_empty[c];
                sel_status.tx_full     = tx_full[c];
                sel_status.tx_empty    = tx_empty[c];
                sel_status.rx_count    = 8'(rx_count[c]);
                sel_status.tx_count    = 8'(tx_count[c]);
                sel_irq_en             = irq_en[c];
            end
        end
    end

    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        if (req) begin
            if (!ch_ok || (data_wr && sel_tx_full)) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!we_i) begin
                    case (rsel)
                        REG_DATA:   if (!sel_rx_empty) rdata_d = data_word(DATA_FIELD_W'(sel_rx_head));
                        REG_STATUS: rdata_d = 32'(sel_status);
                        REG_IRQ_EN: rdata_d = 32'(sel_irq_en);
                        default:    rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= ack_d;
            err_o <= err_d;
            dat_o <= rdata_d;
        end
    end

`ifdef WB_STREAM_HUB_IRQ_EN
    logic irq_d;

    always_comb begin
        irq_d = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            irq_d = irq_d | (irq_en[c][0] & ~rx_empty[c]) | (irq_en[c][1] & tx_empty[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_d;
    end
`endif

endmodule

// File: tb/tb_wb_stream_hub.sv
// Directed bench for wb_stream_hub (NUM_CH=2, DATA_WIDTH=8, depth 16).
// Also covers the irq path when WB_STREAM_HUB_IRQ_EN is defined.
module tb_wb_stream_hub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [31:0] dat_o;
    logic        we  = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack_o;
    logic        err_o;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready = '0;
    logic [15:0] rx_data  = '0;
    logic [1:0]  rx_valid = '0;
    logic [1:0]  rx_ready;
`ifdef WB_STREAM_HUB_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int errors  = 0;
    int last_lat;

    always #5 clk = ~clk;

    wb_stream_hub #(.NUM_CH(2), .DATA_WIDTH(8), .FIFO_DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .adr_i    (adr),
        .dat_i    (dat),
        .dat_o    (dat_o),
        .we_i     (we),
        .sel_i    (sel),
        .stb_i    (stb),
        .cyc_i    (cyc),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
`ifdef WB_STREAM_HUB_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transfer from an idle cycle; returns at posedge+1 of the response cycle.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic ak, output logic er);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        ak = 1'b0; er = 1'b0; rd = '0; last_lat = 0;
        for (int i = 0; i < 4 && !(ak | er); i++) begin
            @(posedge clk); #1;
            last_lat = i + 1;
            ak = ack_o; er = err_o; rd = dat_o;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!(ak | er)) check("bus_timeout", 32'(ak | er), 32'd1);
    endtask

    task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic ak, er;
        bus(1'b0, a, 32'd0, 4'hF, rd, ak, er);
        check(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic ak, er;
        int nerr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        rst = 1'b0;
        check("rst_rx_ready", 32'(rx_ready), 32'd3);
`ifdef WB_STREAM_HUB_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        bus(1'b0, 32'h04, 32'd0, 4'hF, rd, ak, er);
        check("stat0_reset", rd, 32'h0000_0004);
        check("stat0_ack", 32'(ak), 32'd1);
        check("stat0_lat", 32'(last_lat), 32'd1);

        // Two TX words on ch1 held back, then released in order.
        bus(1'b1, 32'h10, 32'h41, 4'h1, rd, ak, er);
        bus(1'b1, 32'h10, 32'h42, 4'h1, rd, ak, er);
        rd_reg(32'h14, 32'h0002_0000, "stat1_tx2");
        check("tx1_valid", 32'(tx_valid), 32'd2);
        check("tx1_head0", 32'(tx_data[15:8]), 32'h41);
        tx_ready = 2'b10;
        @(posedge clk); #1;
        check("tx1_head1", 32'(tx_data[15:8]), 32'h42);
        check("tx1_valid1", 32'(tx_valid[1]), 32'd1);
        @(posedge clk); #1;
        check("tx1_drained", 32'(tx_valid[1]), 32'd0);
        tx_ready = 2'b00;

        // Fill ch0 TX to depth, then overflow.
        nerr = 0;
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, 32'h00, 32'(i), 4'h1, rd, ak, er);
            if (er || !ak) nerr++;
        end
        check("fill_errs", 32'(nerr), 32'd0);
        bus(1'b1, 32'h00, 32'h99, 4'h1, rd, ak, er);
        check("ovf_err", 32'(er), 32'd1);
        check("ovf_ack", 32'(ak), 32'd0);
        rd_reg(32'h04, 32'h0010_0002, "stat0_full");
        tx_ready = 2'b01;
        for (int i = 0; i < 16; i++) begin
            check("drain0", 32'(tx_data[7:0]), 32'(i));
            @(posedge clk); #1;
        end
        tx_ready = 2'b00;
        check("tx0_empty", 32'(tx_valid[0]), 32'd0);

        // RX path on ch0.
        rx_data[7:0] = 8'h5A; rx_valid = 2'b01;
        @(posedge clk); #1;
        rx_valid = 2'b00;
        rd_reg(32'h00, 32'h8000_005A, "rx0_pop");
        rd_reg(32'h00, 32'h0000_0000, "rx0_empty");
        rx_valid = 2'b01;
        for (int k = 0; k < 16; k++) begin
            rx_data[7:0] = 8'(k + 1);
            @(posedge clk); #1;
        end
        rx_valid = 2'b00;
        check("rx0_full_ready", 32'(rx_ready[0]), 32'd0);
        rd_reg(32'h04, 32'h0000_1005, "stat0_rxfull");
        rd_reg(32'h00, 32'h8000_0001, "rx0_first");
        check("rx0_ready_back", 32'(rx_ready[0]), 32'd1);

        // Out-of-range channel and benign accesses.
        bus(1'b1, 32'h20, 32'h55, 4'h1, rd, ak, er);
        check("oor_wr_err", 32'(er), 32'd1);
        check("oor_wr_ack", 32'(ak), 32'd0);
        bus(1'b0, 32'h24, 32'd0, 4'hF, rd, ak, er);
        check("oor_rd_err", 32'(er), 32'd1);
        check("oor_rd_dat", rd, 32'd0);
        rd_reg(32'h14, 32'h0000_0004, "stat1_nochg");
        rd_reg(32'h04, 32'h0000_0F05, "stat0_nochg");
        bus(1'b1, 32'h10, 32'h66, 4'h0, rd, ak, er);
        check("sel0_ack", 32'(ak), 32'd1);
        rd_reg(32'h14, 32'h0000_0004, "stat1_sel0");
        bus(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, ak, er);
        rd_reg(32'h0C, 32'h0000_0000, "reserved_rd");

        // IRQ_EN ch1: rx_nonempty enable, then an RX word on ch1.
        bus(1'b1, 32'h18, 32'h1, 4'h1, rd, ak, er);
`ifdef WB_STREAM_HUB_IRQ_EN
        rd_reg(32'h18, 32'h0000_0001, "irqen1_rd");
        check("irq_idle", 32'(irq), 32'd0);
`else
        rd_reg(32'h18, 32'h0000_0000, "irqen1_rd");
`endif
        rx_data[15:8] = 8'h33; rx_valid = 2'b10;
        @(posedge clk); #1;
        rx_valid = 2'b00;
        @(posedge clk); #1;
`ifdef WB_STREAM_HUB_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
`endif
        rd_reg(32'h10, 32'h8000_0033, "rx1_pop");
        @(posedge clk); #1;
`ifdef WB_STREAM_HUB_IRQ_EN
        check("irq_clr", 32'(irq), 32'd0);
`endif

        // Reset in the middle of a transfer: never acknowledged.
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h10; dat = 32'h77; sel = 4'h1;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_ack0", 32'(ack_o), 32'd0);
        @(posedge clk); #1;
        check("midrst_ack1", 32'(ack_o), 32'd0);
        check("midrst_err1", 32'(err_o), 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ack2", 32'(ack_o), 32'd0);
        check("midrst_txv", 32'(tx_valid), 32'd0);
        check("midrst_rxr", 32'(rx_ready), 32'd3);
        rd_reg(32'h04, 32'h0000_0004, "midrst_stat0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
